pcs_tx_ctrl: RTL and testbench
==============================

// Module: pcs_tx_ctrl
// PURPOSE
//  Transmit-side PCS sequencer ahead of the 8b10b encoder (pcs_tx_8b10b). Takes frame bytes
//  from the MAC over a valid/ready stream and emits one byte+K-flag per cycle to the encoder.
//  Inserts 1000BASE-X ordered sets: /I/ idle pairs, /S/ start, /T/R/ end, /V/ error.
//  Enforces the minimum inter-packet gap and even-column alignment of /S/ and /I/.
// PARAMETERS
//  IPG_MIN   6   minimum idle ordered sets (2 symbols each) between /R/ and next /S/; >=1
//  CNT_W     16  width of frames_sent counter
// PORTS
//  clk           in   1      single clock for all logic
//  rst_n         in   1      asynchronous, active-low reset
//  tx_enable     in   1      1 = frames may start; sampled only at the frame-start decision
//  mac_data      in   8      frame byte
//  mac_valid     in   1      mac_data valid
//  mac_last      in   1      mac_data is the last byte of the frame
//  mac_ready     out  1      byte accepted when mac_valid & mac_ready (combinational from state)
//  enc_rd_pos    in   1      current running disparity from encoder (1 = positive)
//  enc_data      out  8      symbol byte to encoder (registered)
//  enc_k         out  1      1 = control (K) symbol (registered)
//  enc_valid     out  1      symbol valid (registered)
//  busy          out  1      1 in any state other than IDLE_K/IDLE_D
//  frames_sent   out  CNT_W  frames completed with /T/, wraps at 2^CNT_W
//  underrun_cnt  out  8      frames aborted by underrun, saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE_K, enc_data=0, enc_k=0, enc_valid=0, ipg_cnt=0, col=even, counters=0, mac_ready=0.
//  Timing: at each edge, current state selects the symbol registered onto enc_*; state advances
//   on the same edge. Symbol for state S appears on enc_* one cycle after S. enc_valid=1 every cycle after reset.
//  col toggles every emitted symbol. IDLE_K is always even, IDLE_D always odd.
//  States / symbols (data, k):
//   IDLE_K  K28.5 (BC,1) -> IDLE_D.
//   IDLE_D  D16.2 (50,0); D5.6 (C5,0) instead if first IDLE_D after a frame and enc_rd_pos=1.
//           ipg_cnt <= sat(ipg_cnt+1, IPG_MIN). If ipg_cnt+1>=IPG_MIN & tx_enable & mac_valid -> START
//           else -> IDLE_K.
//   START   K27.7 (FB,1), mac_ready=0 -> DATA.
//   DATA    mac_ready=1. mac_valid: emit (mac_data,0); if mac_last -> END_T.
//           !mac_valid (underrun): emit K30.7 (FE,1), underrun_cnt++ (sat) -> DRAIN.
//   DRAIN   mac_ready=1, emit (FE,1) each cycle, discard bytes; accepted mac_last -> END_T.
//   END_T   K29.7 (FD,1); frames_sent++ only if frame not aborted -> END_R.
//   END_R   K23.7 (F7,1); if next symbol col is odd -> END_R2 else -> IDLE_K.
//   END_R2  K23.7 (F7,1) -> IDLE_K.
//  Entering IDLE_K from END_R/END_R2 clears ipg_cnt to 0; from reset ipg_cnt=0 (full IPG after reset).
//  Alignment: /S/ at even col; N data bytes -> N odd gives /T/R/, N even gives /T/R/R/.
//  mac_last with !mac_valid is ignored. tx_enable deassert mid-frame has no effect; frame completes.
//  tx_enable=0 keeps the block cycling idle pairs (enc_valid stays 1).
//  Reset asserted mid-frame: immediate return to reset values; no /T/ emitted, counters cleared.
// TESTING
//  T1 reset release, mac_valid=0: enc_* = (BC,1),(50,0) alternating forever; busy=0; mac_ready=0.
//  T2 IPG_MIN=2, 3-byte frame 11,22,33(last) held valid from reset: after 2 idle pairs ->
//     FB/1,11/0,22/0,33/0,FD/1,F7/1 then BC/1; frames_sent=1.
//  T3 4-byte frame AA..DD: ...,DD/0,FD/1,F7/1,F7/1,BC/1 (extra /R/ realigns to even col).
//  T4 underrun: mac_valid drops after byte 2 of 5, resumes with bytes 3-5: FE/1 for remaining
//     frame cycles, then FD/1,F7/1..; underrun_cnt=1, frames_sent unchanged.
//  T5 enc_rd_pos=1 at first IDLE_D after frame -> (C5,0); later IDLE_D -> (50,0) regardless.
//  T6 rst_n low during DATA for 1 cycle: next outputs reset values, then idle pairs; mac_ready=0
//     until a full IPG_MIN idle pairs pass; tx_enable=0 with mac_valid=1 -> no /S/ ever.

Source files
------------

// File: rtl/pcs_tx_ctrl.sv
// pcs_tx_ctrl
// Transmit-side PCS sequencer that sits ahead of the 8b10b encoder. It takes frame bytes
// from the MAC over a valid/ready stream and emits one byte plus K flag per cycle. It also
// inserts the 1000BASE-X ordered sets: /I/ idle pairs, /S/ start, /T/R/ end and /V/ error.
// The block holds back the next /S/ until the minimum number of idle pairs has been sent.
// It keeps /S/ and /I/ on even columns by adding a second /R/ when the column needs it.
//
// Ports
//   clk           single clock for all logic
//   rst_n         asynchronous, active-low reset
//   tx_enable     frames may start (sampled only at the frame-start decision)
//   mac_data      frame byte from the MAC
//   mac_valid     mac_data valid
//   mac_last      mac_data is the last byte of the frame
//   mac_ready     byte accepted when mac_valid & mac_ready (decoded from state)
//   enc_rd_pos    encoder running disparity, 1 = positive
//   enc_data      registered symbol byte to the encoder
//   enc_k         registered control-symbol flag
//   enc_valid     registered symbol valid, 1 every cycle after reset
//   busy          1 outside the idle pair states
//   frames_sent   frames closed with /T/ that were not aborted, wraps
//   underrun_cnt  frames aborted by MAC underrun, saturates at 255
//
// state   | meaning
// IDLE_K  | first half of /I/ (K28.5), always an even column
// IDLE_D  | second half of /I/, makes the frame-start decision
// START   | /S/ (K27.7)
// DATA    | pass MAC bytes; an underrun turns the frame into /V/
// DRAIN   | aborted frame: emit /V/ and discard bytes until mac_last
// END_T   | /T/ (K29.7)
// END_R   | first /R/ (K23.7)
// END_R2  | second /R/ so that the next /I/ starts on an even column

module pcs_tx_ctrl #(
    parameter int IPG_MIN = 6,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_enable,
    input  logic [7:0]       mac_data,
    input  logic             mac_valid,
    input  logic             mac_last,
    output logic             mac_ready,
    input  logic             enc_rd_pos,
    output logic [7:0]       enc_data,
    output logic             enc_k,
    output logic             enc_valid,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent,
    output logic [7:0]       underrun_cnt
);

    localparam int IPG_W = $clog2(IPG_MIN + 1);
    localparam logic [IPG_W:0] IPG_LIM = (IPG_W + 1)'(IPG_MIN);

    localparam logic [7:0] SYM_K28_5 = 8'hBC;
    localparam logic [7:0] SYM_D16_2 = 8'h50;
    localparam logic [7:0] SYM_D5_6  = 8'hC5;
    localparam logic [7:0] SYM_K27_7 = 8'hFB;
    localparam logic [7:0] SYM_K30_7 = 8'hFE;
    localparam logic [7:0] SYM_K29_7 = 8'hFD;
    localparam logic [7:0] SYM_K23_7 = 8'hF7;

    typedef enum logic [2:0] {
        IDLE_K,
        IDLE_D,
        START,
        DATA,
        DRAIN,
        END_T,
        END_R,
        END_R2
    } state_t;

    state_t           state, state_d;
    logic             col;
    logic [IPG_W-1:0] ipg_cnt, ipg_d;
    logic             first_idle, first_idle_d;
    logic             aborted, aborted_d;
    logic [7:0]       sym_data;
    logic             sym_k;
    logic             frame_inc;
    logic             underrun_inc;

    logic [IPG_W:0]   ipg_inc;
    logic             ipg_reached;
    logic [IPG_W-1:0] ipg_next;

    assign ipg_inc     = {1'b0, ipg_cnt} + {{IPG_W{1'b0}}, 1'b1};
    assign ipg_reached = (ipg_inc >= IPG_LIM);
    assign ipg_next    = ipg_reached ? IPG_LIM[IPG_W-1:0] : ipg_inc[IPG_W-1:0];

    assign mac_ready = (state == DATA) || (state == DRAIN);
    assign busy      = (state != IDLE_K) && (state != IDLE_D);

    always_comb begin
        state_d      = state;
        sym_data     = 8'h00;
        sym_k        = 1'b0;
        ipg_d        = ipg_cnt;
        first_idle_d = first_idle;
        aborted_d    = aborted;
        frame_inc    = 1'b0;
        underrun_inc = 1'b0;
        case (state)
            IDLE_K: begin
                sym_data = SYM_K28_5;
                sym_k    = 1'b1;
                state_d  = IDLE_D;
            end
            IDLE_D: begin
                // D5.6 flips disparity back to negative after a frame that ended positive
                sym_data     = (first_idle && enc_rd_pos) ? SYM_D5_6 : SYM_D16_2;
                first_idle_d = 1'b0;
                ipg_d        = ipg_next;
                if (ipg_reached && tx_enable && mac_valid) begin
                    state_d = START;
                end else begin
                    state_d = IDLE_K;
                end
            end
            START: begin
                sym_data  = SYM_K27_7;
                sym_k     = 1'b1;
                aborted_d = 1'b0;
                state_d   = DATA;
            end
            DATA: begin
                if (mac_valid) begin
                    sym_data = mac_data;
                    if (mac_last) begin
                        state_d = END_T;
                    end
                end else begin
                    sym_data     = SYM_K30_7;
                    sym_k        = 1'b1;
                    underrun_inc = 1'b1;
                    aborted_d    = 1'b1;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                sym_data = SYM_K30_7;
                sym_k    = 1'b1;
                if (mac_valid && mac_last) begin
                    state_d = END_T;
                end
            end
            END_T: begin
                sym_data  = SYM_K29_7;
                sym_k     = 1'b1;
                frame_inc = !aborted;
                state_d   = END_R;
            end
            END_R: begin
                sym_data     = SYM_K23_7;
                sym_k        = 1'b1;
                // Idle follows directly or via END_R2; either way the gap count restarts here
                ipg_d        = '0;
                first_idle_d = 1'b1;
                // col is this symbol's column; an even /R/ leaves the next symbol odd
                state_d      = col ? IDLE_K : END_R2;
            end
            END_R2: begin
                sym_data = SYM_K23_7;
                sym_k    = 1'b1;
                state_d  = IDLE_K;
            end
            default: begin
                state_d = IDLE_K;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_K;
            col        <= 1'b0;
            ipg_cnt    <= '0;
            first_idle <= 1'b0;
            aborted    <= 1'b0;
            enc_data   <= 8'h00;
            enc_k      <= 1'b0;
            enc_valid  <= 1'b0;
        end else begin
            state      <= state_d;
            col        <= ~col;
            ipg_cnt    <= ipg_d;
            first_idle <= first_idle_d;
            aborted    <= aborted_d;
            enc_data   <= sym_data;
            enc_k      <= sym_k;
            enc_valid  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_sent  <= '0;
            underrun_cnt <= 8'h00;
        end else begin
            if (frame_inc) begin
                frames_sent <= frames_sent + CNT_W'(1);
            end
            if (underrun_inc && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_pcs_tx_ctrl.sv
// Bench for pcs_tx_ctrl, built with IPG_MIN = 2.
// The reference model works on the symbol stream rather than on states. It tracks the
// output column parity, whether a frame is open, the queue of control symbols still
// owed, and the count of idle pairs since the last frame.
module tb_pcs_tx_ctrl;

    localparam int IPG = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_enable = 1'b0;
    logic [7:0]  mac_data = 8'h00;
    logic        mac_valid = 1'b0;
    logic        mac_last = 1'b0;
    logic        mac_ready;
    logic        enc_rd_pos = 1'b0;
    logic [7:0]  enc_data;
    logic        enc_k;
    logic        enc_valid;
    logic        busy;
    logic [15:0] frames_sent;
    logic [7:0]  underrun_cnt;

    pcs_tx_ctrl #(.IPG_MIN(IPG), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_enable    (tx_enable),
        .mac_data     (mac_data),
        .mac_valid    (mac_valid),
        .mac_last     (mac_last),
        .mac_ready    (mac_ready),
        .enc_rd_pos   (enc_rd_pos),
        .enc_data     (enc_data),
        .enc_k        (enc_k),
        .enc_valid    (enc_valid),
        .busy         (busy),
        .frames_sent  (frames_sent),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_in_frame;
    bit         m_col;
    int         m_pairs;
    bit         m_first;
    bit         m_abort;
    logic [8:0] m_q[$];
    logic [7:0] m_data;
    logic       m_k;
    logic       m_valid;
    int         m_frames;
    int         m_under;

    logic [8:0] log_q[$];
    logic [8:0] want_q[$];
    logic [7:0] src_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_in_frame && (m_q.size() == 0);
    endfunction

    function automatic bit m_busy();
        return m_in_frame || (m_q.size() != 0);
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_col = 0; m_pairs = 0; m_first = 0; m_abort = 0;
        m_q.delete();
        m_data = 8'h00; m_k = 1'b0; m_valid = 1'b0;
        m_frames = 0; m_under = 0;
    endtask

    task automatic model_edge(input bit te, input bit mv, input bit ml, input logic [7:0] md, input bit rdp);
        logic [8:0] sym;
        if (m_q.size() != 0) begin
            sym = m_q.pop_front();
            if (sym == 9'h1FD && !m_abort) m_frames++;
        end else if (m_in_frame) begin
            if (mv) begin
                sym = m_abort ? 9'h1FE : {1'b0, md};
                if (ml) begin
                    // /T/ and /R/ take the next two columns; the idle that follows must be even
                    m_q.push_back(9'h1FD);
                    m_q.push_back(9'h1F7);
                    if (!m_col) m_q.push_back(9'h1F7);
                    m_in_frame = 0; m_pairs = 0; m_first = 1;
                end
            end else begin
                sym = 9'h1FE;
                if (!m_abort) begin
                    m_abort = 1;
                    if (m_under < 255) m_under++;
                end
            end
        end else if (!m_col) begin
            sym = 9'h1BC;
        end else begin
            sym = (m_first && rdp) ? 9'h0C5 : 9'h050;
            m_first = 0;
            if (m_pairs < IPG) m_pairs++;
            if (m_pairs >= IPG && te && mv) begin
                m_q.push_back(9'h1FB);
                m_in_frame = 1;
                m_abort = 0;
            end
        end
        m_col = ~m_col;
        m_k = sym[8];
        m_data = sym[7:0];
        m_valid = 1'b1;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit te, input bit mv, input bit ml, input logic [7:0] md,
                        input bit rdp, output bit acc);
        bit rdy;
        tx_enable = te; mac_valid = mv; mac_last = ml; mac_data = md; enc_rd_pos = rdp;
        rdy = m_ready();
        #1;
        chk("mac_ready", {31'b0, mac_ready}, {31'b0, rdy});
        chk("busy", {31'b0, busy}, {31'b0, m_busy()});
        acc = mv && rdy;
        @(posedge clk);
        model_edge(te, mv, ml, md, rdp);
        #1;
        chk("enc_data", {24'b0, enc_data}, {24'b0, m_data});
        chk("enc_k", {31'b0, enc_k}, {31'b0, m_k});
        chk("enc_valid", {31'b0, enc_valid}, {31'b0, m_valid});
        chk("frames_sent", {16'b0, frames_sent}, 32'(m_frames & 16'hFFFF));
        chk("underrun_cnt", {24'b0, underrun_cnt}, 32'(m_under));
        log_q.push_back({enc_k, enc_data});
        @(negedge clk);
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        tx_enable = 0; mac_valid = 0; mac_last = 0; mac_data = 8'h00; enc_rd_pos = 0;
        model_reset();
        log_q.delete();
        #1;
        chk("rst_enc_data", {24'b0, enc_data}, 32'h0);
        chk("rst_enc_k", {31'b0, enc_k}, 32'h0);
        chk("rst_enc_valid", {31'b0, enc_valid}, 32'h0);
        chk("rst_mac_ready", {31'b0, mac_ready}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_frames", {16'b0, frames_sent}, 32'h0);
        chk("rst_underrun", {24'b0, underrun_cnt}, 32'h0);
        repeat (cyc) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends src_q as one frame, holding mac_valid low for gap_len DATA-phase cycles after
    // gap_after bytes, then runs four idle cycles with the given disparity.
    task automatic send_frame(input int gap_after, input int gap_len, input bit rdp);
        int idx = 0;
        int gap = 0;
        bit acc;
        log_q.delete();
        for (int c = 0; c < 300 && !(idx == src_q.size() && !m_busy()); c++) begin
            bit mv;
            logic [7:0] md;
            mv = (idx < src_q.size());
            md = mv ? src_q[idx] : 8'h00;
            if (mv && idx == gap_after && gap < gap_len && m_ready()) begin
                mv = 0;
                gap++;
            end
            step(1, mv, mv && (idx == src_q.size() - 1), md, rdp, acc);
            if (acc) idx++;
        end
        chk("frame_done", 32'(idx), 32'(src_q.size()));
        repeat (4) step(1, 0, 0, 8'h00, rdp, acc);
    endtask

    // Compares the logged stream from the first /S/ onwards with want_q.
    task automatic chk_seq(input string tag, input int want_fb);
        int fb = -1;
        for (int i = 0; i < log_q.size(); i++) begin
            if (fb < 0 && log_q[i] == 9'h1FB) fb = i;
        end
        if (want_fb >= 0) chk({tag, "_s_pos"}, 32'(fb), 32'(want_fb));
        for (int i = 0; i < want_q.size(); i++) begin
            logic [31:0] obs;
            obs = (fb >= 0 && fb + i < log_q.size()) ? {23'b0, log_q[fb + i]} : 32'hDEAD;
            chk(tag, obs, {23'b0, want_q[i]});
        end
    endtask

    initial begin
        bit acc;
        int fb_seen;
        logic [7:0] fr[$];
        int fidx;

        do_reset(3);

        // idle only: K28.5 / D16.2 pairs
        repeat (8) step(1, 0, 0, 8'h00, 0, acc);
        chk("t1_busy", {31'b0, busy}, 32'h0);

        // 3-byte frame held valid from reset
        do_reset(1);
        src_q = {8'h11, 8'h22, 8'h33};
        send_frame(99, 0, 0);
        want_q = {9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1FD, 9'h1F7, 9'h1BC, 9'h050, 9'h1BC, 9'h050};
        chk_seq("t2_seq", 4);
        chk("t2_frames", {16'b0, frames_sent}, 32'd1);

        // 4-byte frame needs a second /R/; positive disparity gives D5.6 once
        src_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(99, 0, 1);
        want_q = {9'h1FB, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h1FD, 9'h1F7, 9'h1F7,
                  9'h1BC, 9'h0C5, 9'h1BC, 9'h050};
        chk_seq("t3_seq", -1);

        // underrun after two bytes of five
        src_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(2, 3, 0);
        want_q = {9'h1FB, 9'h001, 9'h002, 9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE,
                  9'h1FD, 9'h1F7, 9'h1F7, 9'h1BC, 9'h050};
        chk_seq("t4_seq", -1);
        chk("t4_underrun", {24'b0, underrun_cnt}, 32'd1);
        chk("t4_frames", {16'b0, frames_sent}, 32'd2);

        // reset in the middle of a frame, then tx_enable low with data waiting
        src_q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        for (int c = 0; c < 20 && !m_ready(); c++) step(1, 1, 0, 8'h61, 0, acc);
        step(1, 1, 0, 8'h61, 0, acc);
        chk("t6_in_data", {31'b0, acc}, 32'h1);
        do_reset(1);
        repeat (30) step(0, 1, 0, 8'h77, 0, acc);
        fb_seen = 0;
        foreach (log_q[i]) if (log_q[i] == 9'h1FB) fb_seen++;
        chk("t6_no_start", 32'(fb_seen), 32'd0);
        repeat (6) step(1, 1, 1, 8'h78, 0, acc);

        // underrun counter saturation
        for (int f = 0; f < 260; f++) begin
            for (int c = 0; c < 40 && !m_ready(); c++) step(1, 1, 1, 8'h55, 0, acc);
            step(1, 0, 1, 8'h55, 0, acc);
            step(1, 1, 1, 8'h56, 0, acc);
        end
        chk("sat_underrun", {24'b0, underrun_cnt}, 32'd255);

        // randomized traffic
        fidx = 0;
        for (int c = 0; c < 1500; c++) begin
            bit mv, ml, te, rdp;
            logic [7:0] md;
            if (fr.size() == 0) begin
                int n;
                n = $urandom_range(1, 8);
                for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
                fidx = 0;
            end
            mv  = ($urandom_range(0, 9) != 0);
            md  = fr[fidx];
            ml  = mv ? (fidx == fr.size() - 1) : 1'($urandom_range(0, 1));
            te  = ($urandom_range(0, 9) != 0);
            rdp = 1'($urandom_range(0, 1));
            step(te, mv, ml, md, rdp, acc);
            if (acc) begin
                fidx++;
                if (fidx == fr.size()) fr.delete();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
